// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the fetch/data single-port memory arbiter.
package mem_arb_pkg;

   localparam int AW_DEF            = 10;
   localparam int DW_DEF            = 32;
   localparam int MAX_DM_STREAK_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESP_IF = 2'd1,
      RESP_DM = 2'd2
   } resp_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between instruction fetch and data memory.
// Data wins by default; fetch is forced through after MAX_DM_STREAK data grants.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no read response due this cycle
// RESP_IF | mem_rdata carries the fetch read granted last cycle
// RESP_DM | mem_rdata carries the data read granted last cycle
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW            = AW_DEF,
   parameter int DW            = DW_DEF,
   parameter int MAX_DM_STREAK = MAX_DM_STREAK_DEF
) (
   input  logic          CLK_50,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

   resp_state_t state;
   logic [3:0]  streak;
   logic        fetch_turn;

   // Grants depend only on requests and registered state, never on mem_rdata.
   assign fetch_turn = if_req & (streak == STREAK_MAX);
   assign dm_gnt     = dm_req & ~fetch_turn;
   assign if_gnt     = if_req & ~dm_gnt;
   assign stall_if   = if_req & ~if_gnt;
   assign stall_mem  = dm_req & ~dm_gnt;

   assign mem_en    = if_gnt | dm_gnt;
   assign mem_we    = dm_gnt & dm_we;
   assign mem_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
   assign mem_wdata = dm_wdata;

   // Masking with reset drops a response whose access was granted just before reset.
   assign if_rvalid = (state == RESP_IF) & ~reset;
   assign dm_rvalid = (state == RESP_DM) & ~reset;
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

   always_ff @(posedge CLK_50) begin
      if (reset) begin
         state  <= IDLE;
         streak <= '0;
      end else begin
         if (!if_req || if_gnt) begin
            streak <= '0;
         end else if (dm_gnt && (streak != STREAK_MAX)) begin
            streak <= streak + 4'd1;
         end

         if (if_gnt) begin
            state <= RESP_IF;
         end else if (dm_gnt && !dm_we) begin
            state <= RESP_DM;
         end else begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle arbitration and reset
// sequences, then constrained-random traffic against a request-level reference model.
module tb_mem_port_arbiter;

   localparam int AW   = 10;
   localparam int DW   = 32;
   localparam int MAXS = 4;

   logic          CLK_50 = 1'b0;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt;
   logic          dm_rvalid;
   logic [DW-1:0] dm_rdata;
   logic          stall_if;
   logic          stall_mem;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] ram    [1024];
   logic [DW-1:0] shadow [1024];

   int n_cmp = 0;
   int n_err = 0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DM_STREAK(MAXS)) dut (
      .CLK_50   (CLK_50),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_rvalid(if_rvalid),
      .if_rdata (if_rdata),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_gnt   (dm_gnt),
      .dm_rvalid(dm_rvalid),
      .dm_rdata (dm_rdata),
      .stall_if (stall_if),
      .stall_mem(stall_mem),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 CLK_50 = ~CLK_50;

   // Single-port synchronous RAM: read data appears the cycle after the access.
   always @(posedge CLK_50) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] = mem_wdata;
         else        mem_rdata    <= ram[mem_addr];
      end
   end

   typedef struct {
      logic        ifr;
      logic [9:0]  ia;
      logic        dmr;
      logic        dwe;
      logic [9:0]  da;
      logic [31:0] dwd;
      logic        eifg;
      logic        edmg;
      logic        ewe;
      logic [9:0]  eaddr;
      logic        eifrv;
      logic        edmrv;
      logic [31:0] erd;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(logic ifr, int ia, logic dmr, logic dwe, int da, logic [31:0] dwd,
                               logic eifg, logic edmg, logic ewe, int eaddr,
                               logic eifrv, logic edmrv, logic [31:0] erd);
      vec_t v;
      v.ifr = ifr;   v.ia = 10'(ia);  v.dmr = dmr;   v.dwe = dwe;   v.da = 10'(da);
      v.dwd = dwd;   v.eifg = eifg;   v.edmg = edmg; v.ewe = ewe;   v.eaddr = 10'(eaddr);
      v.eifrv = eifrv; v.edmrv = edmrv; v.erd = erd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic ifr, input int ia, input logic dmr,
                        input logic dwe, input int da, input logic [31:0] dwd);
      reset    = rst;
      if_req   = ifr;
      if_addr  = AW'(ia);
      dm_req   = dmr;
      dm_we    = dwe;
      dm_addr  = AW'(da);
      dm_wdata = dwd;
   endtask

   task automatic next();
      @(posedge CLK_50);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
      next();
   endtask

   // Both ports request continuously; fetch is expected only in the cycles set in exp_f.
   task automatic arb_pattern(input string nm, input int n, input logic [15:0] ifr_mask,
                              input logic [15:0] exp_f);
      for (int k = 0; k < n; k++) begin
         drive(1'b0, ifr_mask[k], 3, 1'b1, 1'b1, 9, 32'h5A5A_0009);
         @(negedge CLK_50);
         chk({nm, "_if_gnt"},    32'(if_gnt),    32'(exp_f[k]));
         chk({nm, "_dm_gnt"},    32'(dm_gnt),    32'(!exp_f[k]));
         chk({nm, "_stall_if"},  32'(stall_if),  32'(ifr_mask[k] & !exp_f[k]));
         chk({nm, "_stall_mem"}, 32'(stall_mem), 32'(exp_f[k]));
         next();
      end
   endtask

   logic        f_pend, d_pend, r_dwe, fwin, dwin;
   logic        exp_ifrv, exp_dmrv;
   logic [31:0] r_dwd, exp_rd;
   int          r_fa, r_da, dm_run;

   initial begin
      ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33;
      ram[7] = 32'h77; ram[8] = 32'h88;

      tbl[0]  = mk(1,0, 0,0,0,32'h0,        1,0,0,0, 0,0,32'h0);
      tbl[1]  = mk(1,1, 0,0,0,32'h0,        1,0,0,1, 1,0,32'h11);
      tbl[2]  = mk(1,2, 0,0,0,32'h0,        1,0,0,2, 1,0,32'h22);
      tbl[3]  = mk(0,0, 0,0,0,32'h0,        0,0,0,0, 1,0,32'h33);
      tbl[4]  = mk(0,0, 1,1,5,32'hDEADBEEF, 0,1,1,5, 0,0,32'h0);
      tbl[5]  = mk(0,0, 1,0,5,32'h12345678, 0,1,0,5, 0,0,32'h0);
      tbl[6]  = mk(0,0, 0,0,0,32'h0,        0,0,0,0, 0,1,32'hDEADBEEF);
      tbl[7]  = mk(0,0, 1,0,7,32'h0,        0,1,0,7, 0,0,32'h0);
      tbl[8]  = mk(1,8, 0,0,0,32'h0,        1,0,0,8, 0,1,32'h77);
      tbl[9]  = mk(0,0, 1,0,0,32'h0,        0,1,0,0, 1,0,32'h88);
      tbl[10] = mk(1,2, 0,0,0,32'h0,        1,0,0,2, 0,1,32'h11);
      tbl[11] = mk(0,0, 0,0,0,32'h0,        0,0,0,0, 1,0,32'h33);
      tbl[12] = mk(1,1, 1,0,7,32'h0,        0,1,0,7, 0,0,32'h0);
      tbl[13] = mk(1,1, 0,0,0,32'h0,        1,0,0,1, 0,1,32'h77);
      tbl[14] = mk(0,0, 0,0,0,32'h0,        0,0,0,0, 1,0,32'h22);

      // Reset with no requests: all outputs quiet, mem_wdata follows dm_wdata.
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 32'hA5A5_A5A5);
      repeat (2) @(posedge CLK_50);
      #1;
      @(negedge CLK_50);
      chk("rst_if_gnt",    32'(if_gnt),    32'h0);
      chk("rst_dm_gnt",    32'(dm_gnt),    32'h0);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
      chk("rst_dm_rvalid", 32'(dm_rvalid), 32'h0);
      chk("rst_if_rdata",  if_rdata,       32'h0);
      chk("rst_dm_rdata",  dm_rdata,       32'h0);
      chk("rst_stall_if",  32'(stall_if),  32'h0);
      chk("rst_stall_mem", 32'(stall_mem), 32'h0);
      chk("rst_mem_en",    32'(mem_en),    32'h0);
      chk("rst_mem_we",    32'(mem_we),    32'h0);
      chk("rst_mem_addr",  32'(mem_addr),  32'h0);
      chk("rst_mem_wdata", mem_wdata,      32'hA5A5_A5A5);
      next();

      // A request during reset is granted, but its response is discarded.
      drive(1'b1, 1'b1, 3, 1'b0, 1'b0, 0, 32'h0);
      @(negedge CLK_50);
      chk("rstreq_if_gnt",   32'(if_gnt),   32'h1);
      chk("rstreq_stall_if", 32'(stall_if), 32'h0);
      chk("rstreq_mem_addr", 32'(mem_addr), 32'h3);
      next();
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
      @(negedge CLK_50);
      chk("rstreq_if_rvalid", 32'(if_rvalid), 32'h0);
      next();

      for (int i = 0; i < 15; i++) begin
         drive(1'b0, tbl[i].ifr, int'(tbl[i].ia), tbl[i].dmr, tbl[i].dwe, int'(tbl[i].da), tbl[i].dwd);
         @(negedge CLK_50);
         chk($sformatf("vec%0d_if_gnt", i),    32'(if_gnt),    32'(tbl[i].eifg));
         chk($sformatf("vec%0d_dm_gnt", i),    32'(dm_gnt),    32'(tbl[i].edmg));
         chk($sformatf("vec%0d_stall_if", i),  32'(stall_if),  32'(tbl[i].ifr & !tbl[i].eifg));
         chk($sformatf("vec%0d_stall_mem", i), 32'(stall_mem), 32'(tbl[i].dmr & !tbl[i].edmg));
         chk($sformatf("vec%0d_mem_en", i),    32'(mem_en),    32'(tbl[i].eifg | tbl[i].edmg));
         chk($sformatf("vec%0d_mem_we", i),    32'(mem_we),    32'(tbl[i].ewe));
         if (tbl[i].eifg | tbl[i].edmg)
            chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].eaddr));
         chk($sformatf("vec%0d_mem_wdata", i), mem_wdata,      tbl[i].dwd);
         chk($sformatf("vec%0d_if_rvalid", i), 32'(if_rvalid), 32'(tbl[i].eifrv));
         chk($sformatf("vec%0d_dm_rvalid", i), 32'(dm_rvalid), 32'(tbl[i].edmrv));
         if (tbl[i].eifrv) chk($sformatf("vec%0d_if_rdata", i), if_rdata, tbl[i].erd);
         if (tbl[i].edmrv) chk($sformatf("vec%0d_dm_rdata", i), dm_rdata, tbl[i].erd);
         next();
      end

      // Continuous contention: D,D,D,D,F repeating.
      idle();
      arb_pattern("rr", 15, 16'hFFFF, 16'b0100_0010_0001_0000);

      // Fetch drops for one cycle after two data grants; the streak restarts.
      idle();
      arb_pattern("clr", 8, 16'b0000_0000_1111_1011, 16'b0000_0000_1000_0000);

      // Reset the cycle after a fetch grant: the response never appears.
      idle();
      drive(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 32'h0);
      @(negedge CLK_50);
      chk("flight_if_gnt", 32'(if_gnt), 32'h1);
      next();
      drive(1'b1, 1'b1, 2, 1'b1, 1'b0, 1, 32'h0);
      @(negedge CLK_50);
      chk("flight_if_rvalid", 32'(if_rvalid), 32'h0);
      chk("flight_dm_gnt",    32'(dm_gnt),    32'h1);
      chk("flight_if_gnt2",   32'(if_gnt),    32'h0);
      next();
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
      @(negedge CLK_50);
      chk("after_rst_if_rvalid", 32'(if_rvalid), 32'h0);
      chk("after_rst_dm_rvalid", 32'(dm_rvalid), 32'h0);
      next();

      // Streak of 2 wiped by reset: four more data grants before fetch.
      arb_pattern("pre_rst", 2, 16'h0003, 16'h0000);
      drive(1'b1, 1'b1, 3, 1'b1, 1'b1, 9, 32'h5A5A_0009);
      @(negedge CLK_50);
      chk("rst_streak_dm_gnt", 32'(dm_gnt), 32'h1);
      next();
      arb_pattern("post_rst", 5, 16'h001F, 16'h0010);

      // Random traffic against a request-level model.
      idle();
      for (int a = 0; a < 1024; a++) shadow[a] = ram[a];
      f_pend = 1'b0; d_pend = 1'b0; dm_run = 0;
      exp_ifrv = 1'b0; exp_dmrv = 1'b0; exp_rd = 32'h0;
      r_fa = 0; r_da = 0; r_dwe = 1'b0; r_dwd = 32'h0;
      for (int c = 0; c < 2000; c++) begin
         if (!f_pend) begin
            f_pend = ($urandom_range(0, 3) != 0);
            r_fa   = int'($urandom_range(0, 15));
         end
         if (!d_pend) begin
            d_pend = ($urandom_range(0, 2) != 0);
            r_dwe  = ($urandom_range(0, 2) == 0);
            r_da   = int'($urandom_range(0, 15));
            r_dwd  = $urandom;
         end
         drive(1'b0, f_pend, r_fa, d_pend, r_dwe, r_da, r_dwd);
         fwin = (f_pend && d_pend) ? (dm_run >= MAXS) : f_pend;
         dwin = d_pend && !fwin;
         @(negedge CLK_50);
         chk("rnd_if_gnt",    32'(if_gnt),    32'(fwin));
         chk("rnd_dm_gnt",    32'(dm_gnt),    32'(dwin));
         chk("rnd_stall_if",  32'(stall_if),  32'(f_pend && !fwin));
         chk("rnd_stall_mem", 32'(stall_mem), 32'(d_pend && !dwin));
         chk("rnd_mem_en",    32'(mem_en),    32'(fwin || dwin));
         chk("rnd_mem_we",    32'(mem_we),    32'(dwin && r_dwe));
         if (fwin || dwin) chk("rnd_mem_addr", 32'(mem_addr), 32'(fwin ? r_fa : r_da));
         chk("rnd_if_rvalid", 32'(if_rvalid), 32'(exp_ifrv));
         chk("rnd_dm_rvalid", 32'(dm_rvalid), 32'(exp_dmrv));
         if (exp_ifrv) chk("rnd_if_rdata", if_rdata, exp_rd);
         if (exp_dmrv) chk("rnd_dm_rdata", dm_rdata, exp_rd);

         exp_ifrv = fwin;
         exp_dmrv = dwin && !r_dwe;
         exp_rd   = fwin ? shadow[r_fa] : shadow[r_da];
         if (dwin && r_dwe) shadow[r_da] = r_dwd;
         if (!f_pend || fwin)           dm_run = 0;
         else if (dwin && dm_run < MAXS) dm_run = dm_run + 1;
         if (fwin) f_pend = 1'b0;
         if (dwin) d_pend = 1'b0;
         next();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
